serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder/subtractor controller that time-shares a single `full_adder` cell across a WIDTH-bit operation, one bit per clock, LSB first. It sits between a requester issuing operand pairs with a start/done handshake and the one-bit `full_adder` datapath. It provides a small-area alternative to the ripple-carry adder for the same arithmetic.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- sub  in  1  0 = A+B+Cin, 1 = A−B (B inverted, carry-in forced 1, Cin ignored); captured with start
- A  in  WIDTH  operand A; captured with start
- B  in  WIDTH  operand B; captured with start
- Cin  in  1  carry-in for add; captured with start
- busy  out  1  high while an operation is in progress (RUN)
- done  out  1  one-cycle pulse when S/Cout/ovf are valid
- S  out  WIDTH  result; holds until the next accepted start
- Cout  out  1  final carry-out (for sub: 1 = no borrow)
- ovf  out  1  signed overflow = carry into MSB XOR Cout

## Operation
- Instantiates one `full_adder` with ports (A, B, Cin, S, Cout). Its inputs come from the LSB of the A shift register, the LSB of the B shift register XOR sub_q, and a carry register.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on start=1, capture A, B, sub and the initial carry. Initial carry = sub ? 1 : Cin. Clear the bit counter, clear S, and go to RUN. With start=0, stay in IDLE.
  - RUN: each cycle, shift the full_adder sum bit into S from the MSB side. Shift S, A and B right by one. Load the carry register with the full_adder carry-out and increment the counter.
    - When the counter reaches WIDTH−1, the current edge processes the last bit. On that edge: latch Cout from the full_adder carry, latch ovf = (carry register) XOR (full_adder carry), and go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start is ignored in RUN and DONE. It is not queued, and operands presented then are discarded.
- Register widths:
  - counter: clog2(WIDTH) bits.
  - A, B, S shift registers: WIDTH bits.
  - carry, sub_q: 1 bit each.
- Result equals (A + (sub ? ~B : B) + carry0) mod 2^WIDTH. Cout is bit WIDTH of that sum.

## Timing
- Reset (asynchronous, any state including mid-RUN): state=IDLE, busy=0, done=0, S=0, Cout=0, ovf=0, counter=0, carry=0. The operation is abandoned with no done pulse.
- Reset deassertion: the first start is accepted on the first rising edge with reset=0.
- Let E0 be the edge where start is accepted in IDLE:
  - busy=1 from after E0 until after edge E0+WIDTH.
  - Bit i is computed combinationally in the cycle after E0+i and registered at E0+i+1.
  - S, Cout and ovf are final after E0+WIDTH.
  - done=1 in the cycle between E0+WIDTH and E0+WIDTH+1.
- Latency: WIDTH cycles from the start edge to done. Throughput: one operation per WIDTH+2 cycles (a new start is accepted at E0+WIDTH+2 at earliest).
- Intermediate S contents during RUN are not valid. Consumers must use done.
- start asserted in the same cycle as done is ignored, because the FSM is in DONE.

## Test plan
- WIDTH=8, reset then start with A=8'h35, B=8'h2A, Cin=0, sub=0 -> S=8'h5F, Cout=0, ovf=0; done pulses exactly 8 cycles after the start edge, one cycle wide; busy high for 8 cycles.
- A=8'hFF, B=8'h01, Cin=0, sub=0 -> S=8'h00, Cout=1, ovf=0. Then A=8'h7F, B=8'h00, Cin=1 -> S=8'h80, Cout=0, ovf=1.
- Subtract: A=8'h10, B=8'h01, sub=1, Cin=1 (ignored) -> S=8'h0F, Cout=1, ovf=0. Then A=8'h00, B=8'h01, sub=1 -> S=8'hFF, Cout=0, ovf=0.
- start held high continuously with A=8'h01, B=8'h02: accepted operations complete every 10 cycles with S=8'h03. Mid-run changes to A/B (e.g. A=8'hAA) do not affect the result in flight.
- Assert reset at cycle 4 of a RUN -> busy, done, S, Cout, ovf go to 0 immediately and no done pulse occurs. After release, A=8'h80, B=8'h80 -> S=8'h00, Cout=1, ovf=1.
- Exhaustive at WIDTH=4: all A, B, Cin, sub combinations compared against a reference sum for S, Cout and ovf on every done.

Source files
------------

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle for the bit-serial adder controller.
// The requester drives the master side; the controller takes the slave side.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             ovf;

  modport master (
    output start, sub, A, B, Cin,
    input  busy, done, S, Cout, ovf
  );

  modport slave (
    input  start, sub, A, B, Cin,
    output busy, done, S, Cout, ovf
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full_adder cell is reused for
// WIDTH clocks, LSB first, with a start/done handshake toward the requester.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);
  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  serial_add_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] s_q;
  logic             carry_q;
  logic             sub_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;

  logic             fa_s;
  logic             fa_co;

  // Subtraction feeds ~B through the same cell; the forced carry-in completes
  // the two's complement.
  full_adder u_fa (
    .A    (a_q[0]),
    .B    (b_q[0] ^ sub_q),
    .Cin  (carry_q),
    .S    (fa_s),
    .Cout (fa_co)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            sub_q   <= bus.sub;
            carry_q <= bus.sub ? 1'b1 : bus.Cin;
            cnt_q   <= '0;
            s_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          s_q     <= {fa_s, s_q[WIDTH-1:1]};
          a_q     <= {1'b0, a_q[WIDTH-1:1]};
          b_q     <= {1'b0, b_q[WIDTH-1:1]};
          carry_q <= fa_co;
          cnt_q   <= cnt_q + CW'(1);
          // carry_q here is the carry into the MSB, so ovf compares it with the MSB carry-out.
          if (cnt_q == LAST) begin
            cout_q  <= fa_co;
            ovf_q   <= carry_q ^ fa_co;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.S    = s_q;
  assign bus.Cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed and random operations at WIDTH=8 and an
// exhaustive sweep at WIDTH=4, checked against an arithmetic reference.
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_add_ctrl_if #(.WIDTH(8)) b8 ();
  serial_add_ctrl_if #(.WIDTH(4)) b4 ();

  serial_add_ctrl #(.WIDTH(8)) u8 (.clk(clk), .reset(reset), .bus(b8));
  serial_add_ctrl #(.WIDTH(4)) u4 (.clk(clk), .reset(reset), .bus(b4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain WIDTH+1-bit arithmetic and sign-rule overflow.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic cin, input logic sub,
                                output logic [31:0] s, output logic co, output logic ov);
    logic [63:0] mask, bo, full;
    mask = (64'd1 << w) - 64'd1;
    bo   = sub ? (~{32'd0, b} & mask) : {32'd0, b};
    full = {32'd0, a} + bo + {63'd0, (sub ? 1'b1 : cin)};
    s    = 32'(full & mask);
    co   = full[w];
    ov   = (a[w-1] == bo[w-1]) && (s[w-1] != a[w-1]);
  endfunction

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic sub, input string tag);
    logic [31:0] es;
    logic        ec, eo;
    model(8, {24'd0, a}, {24'd0, b}, cin, sub, es, ec, eo);
    @(negedge clk);
    b8.start = 1'b1; b8.A = a; b8.B = b; b8.Cin = cin; b8.sub = sub;
    @(posedge clk); #1;
    b8.start = 1'b0;
    check({tag, "_busy0"}, {31'd0, b8.busy}, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      check($sformatf("%s_bd%0d", tag, k), {30'd0, b8.busy, b8.done},
            (k < 8) ? 32'd2 : 32'd1);
    end
    check({tag, "_S"}, {24'd0, b8.S}, es);
    check({tag, "_Cout"}, {31'd0, b8.Cout}, {31'd0, ec});
    check({tag, "_ovf"}, {31'd0, b8.ovf}, {31'd0, eo});
    @(posedge clk); #1;
    check({tag, "_done_off"}, {31'd0, b8.done}, 32'd0);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic sub);
    logic [31:0] es;
    logic        ec, eo;
    bit          seen;
    model(4, {28'd0, a}, {28'd0, b}, cin, sub, es, ec, eo);
    @(negedge clk);
    b4.start = 1'b1; b4.A = a; b4.B = b; b4.Cin = cin; b4.sub = sub;
    @(posedge clk); #1;
    b4.start = 1'b0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk); #1;
      seen = b4.done;
    end
    if (!seen) check("w4_timeout", 32'd0, 32'd1);
    check($sformatf("w4_%h_%h_%b%b", a, b, cin, sub),
          {26'd0, b4.Cout, b4.ovf, b4.S}, {26'd0, ec, eo, es[3:0]});
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] es;
    logic        ec, eo;
    int          last_done;
    bit          seen;
    b8.start = 0; b8.sub = 0; b8.A = '0; b8.B = '0; b8.Cin = 0;
    b4.start = 0; b4.sub = 0; b4.A = '0; b4.B = '0; b4.Cin = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {21'd0, b8.busy, b8.done, b8.S, b8.Cout, b8.ovf}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    op8(8'h35, 8'h2A, 1'b0, 1'b0, "add35_2a");
    op8(8'hFF, 8'h01, 1'b0, 1'b0, "addff_01");
    op8(8'h7F, 8'h00, 1'b1, 1'b0, "add7f_cin");
    op8(8'h10, 8'h01, 1'b1, 1'b1, "sub10_01");
    op8(8'h00, 8'h01, 1'b0, 1'b1, "sub00_01");

    // start held high: back-to-back ops every WIDTH+2 cycles, A changed mid-run
    model(8, 32'h01, 32'h02, 1'b0, 1'b0, es, ec, eo);
    @(negedge clk);
    b8.start = 1'b1; b8.A = 8'h01; b8.B = 8'h02; b8.Cin = 0; b8.sub = 0;
    last_done = 0;
    for (int op = 0; op < 3; op++) begin
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(posedge clk); #1;
        if (k == 3) b8.A = 8'hAA;
        seen = b8.done;
      end
      if (!seen) check("held_timeout", 32'd0, 32'd1);
      check($sformatf("held_S%0d", op), {24'd0, b8.S}, es);
      if (op > 0) check($sformatf("held_gap%0d", op), 32'(cyc - last_done), 32'd10);
      last_done = cyc;
      b8.A = 8'h01;
    end
    @(negedge clk);
    b8.start = 1'b0;
    repeat (12) @(posedge clk);

    // Reset in the middle of RUN
    @(negedge clk);
    b8.start = 1'b1; b8.A = 8'h55; b8.B = 8'h33;
    @(posedge clk); #1;
    b8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_state", {21'd0, b8.busy, b8.done, b8.S, b8.Cout, b8.ovf}, 32'd0);
    seen = 0;
    repeat (2) begin @(posedge clk); #1; seen |= b8.done; end
    @(negedge clk);
    reset = 1'b0;
    repeat (10) begin @(posedge clk); #1; seen |= b8.done; end
    check("midrst_nodone", {31'd0, seen}, 32'd0);
    op8(8'h80, 8'h80, 1'b0, 1'b0, "add80_80");

    for (int i = 0; i < 20; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), $sformatf("rnd%0d", i));

    for (int unsigned a = 0; a < 16; a++)
      for (int unsigned b = 0; b < 16; b++)
        for (int unsigned m = 0; m < 4; m++)
          op4(4'(a), 4'(b), m[0], m[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
